// File: rtl/vin_mixer_ctrl.sv
// vin_mixer_ctrl: frame-synchronous mode/offset controller and colour-filter phase generator for the video-input mixer.
// Optional line-length checker is built when VIN_MIXCTL_LINECHK_EN is defined; otherwise line_err is tied low.
module vin_mixer_ctrl #(
  parameter int PHASES = 3,
  parameter int XW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_mode,
  input  logic [1:0]    cfg_xoff,
  input  logic [1:0]    cfg_yoff,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          in_vsync,
  input  logic          in_hsync,
  input  logic          in_valid,
  output logic [1:0]    mode,
  output logic [1:0]    phase_x,
  output logic [1:0]    phase_y,
  output logic          frame_start,
  output logic [XW-1:0] beat_cnt,
  output logic [XW-1:0] line_cnt,
  output logic          line_err
);

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_DES  = 2'd1;
  localparam logic [1:0] MODE_KAL  = 2'd2;
  localparam logic [1:0] MODE_RSV  = 2'd3;

  function automatic logic [1:0] phase_inc(input logic [1:0] p);
    if (int'(p) >= PHASES - 1) return 2'd0;
    return p + 2'd1;
  endfunction

  function automatic logic [1:0] off_clamp(input logic [1:0] o);
    if (int'(o) >= PHASES) return 2'd0;
    return o;
  endfunction

  // control state (reset)
  logic          vs_last_q, vs_last_d;
  logic          hs_last_q, hs_last_d;
  logic          pending_q, pending_d;
  logic          first_line_q, first_line_d;
  logic          frame_start_q, frame_start_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    phase_x_q, phase_x_d;
  logic [1:0]    phase_y_q, phase_y_d;
  logic [XW-1:0] beat_cnt_q, beat_cnt_d;
  logic [XW-1:0] line_cnt_q, line_cnt_d;

  // configuration payload (qualified by pending_q / mode_q, so left unreset)
  logic [1:0]    pend_mode_q, pend_mode_d;
  logic [1:0]    pend_xoff_q, pend_xoff_d;
  logic [1:0]    pend_yoff_q, pend_yoff_d;
  logic [1:0]    act_xoff_q, act_xoff_d;
  logic [1:0]    act_yoff_q, act_yoff_d;

`ifdef VIN_MIXCTL_LINECHK_EN
  logic          line_err_q, line_err_d;
  logic          ref_vld_q, ref_vld_d;
  logic [XW-1:0] ref_len_q, ref_len_d;
`endif

  logic vs_rise, hs_rise, xfer;

  assign vs_rise = in_vsync & ~vs_last_q;
  assign hs_rise = in_hsync & ~hs_last_q;
  assign xfer    = cfg_valid & ~pending_q;

  always_comb begin
    vs_last_d     = in_vsync;
    hs_last_d     = in_hsync;
    pending_d     = pending_q;
    first_line_d  = first_line_q;
    frame_start_d = 1'b0;
    mode_d        = mode_q;
    phase_x_d     = phase_x_q;
    phase_y_d     = phase_y_q;
    beat_cnt_d    = beat_cnt_q;
    line_cnt_d    = line_cnt_q;
    pend_mode_d   = pend_mode_q;
    pend_xoff_d   = pend_xoff_q;
    pend_yoff_d   = pend_yoff_q;
    act_xoff_d    = act_xoff_q;
    act_yoff_d    = act_yoff_q;
`ifdef VIN_MIXCTL_LINECHK_EN
    line_err_d    = line_err_q;
    ref_vld_d     = ref_vld_q;
    ref_len_d     = ref_len_q;
`endif

    // Reserved mode is folded to mono at acceptance so the active mode is always 0..2.
    if (xfer) begin
      pending_d   = 1'b1;
      pend_mode_d = (cfg_mode == MODE_RSV) ? MODE_MONO : cfg_mode;
      pend_xoff_d = off_clamp(cfg_xoff);
      pend_yoff_d = off_clamp(cfg_yoff);
    end

    if (vs_rise) begin
      if (pending_q) begin
        pending_d  = 1'b0;
        mode_d     = pend_mode_q;
        act_xoff_d = pend_xoff_q;
        act_yoff_d = pend_yoff_q;
`ifdef VIN_MIXCTL_LINECHK_EN
        line_err_d = 1'b0;
`endif
      end
      phase_x_d     = act_xoff_d;
      phase_y_d     = act_yoff_d;
      beat_cnt_d    = '0;
      line_cnt_d    = '0;
      first_line_d  = 1'b1;
      frame_start_d = 1'b1;
`ifdef VIN_MIXCTL_LINECHK_EN
      ref_vld_d     = 1'b0;
`endif
    end else if (hs_rise) begin
      // The hsync that opens the first line of a frame ends no line.
      if (!first_line_q) begin
        phase_y_d  = phase_inc(phase_y_q);
        phase_x_d  = phase_inc(phase_y_q);
        line_cnt_d = line_cnt_q + XW'(1);
        beat_cnt_d = '0;
`ifdef VIN_MIXCTL_LINECHK_EN
        if (ref_vld_q) begin
          if (beat_cnt_q != ref_len_q) line_err_d = 1'b1;
        end else if (beat_cnt_q != '0) begin
          ref_len_d = beat_cnt_q;
          ref_vld_d = 1'b1;
        end
`endif
      end
    end else if (in_valid) begin
      first_line_d = 1'b0;
      if (!(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + XW'(1);
      if (mode_q == MODE_DES) phase_x_d = phase_inc(phase_x_q);
    end

    if (mode_d != MODE_DES && mode_d != MODE_KAL) begin
      phase_x_d = 2'd0;
      phase_y_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_last_q     <= 1'b1;
      hs_last_q     <= 1'b1;
      pending_q     <= 1'b0;
      first_line_q  <= 1'b1;
      frame_start_q <= 1'b0;
      mode_q        <= MODE_MONO;
      phase_x_q     <= 2'd0;
      phase_y_q     <= 2'd0;
      beat_cnt_q    <= '0;
      line_cnt_q    <= '0;
`ifdef VIN_MIXCTL_LINECHK_EN
      line_err_q    <= 1'b0;
      ref_vld_q     <= 1'b0;
`endif
    end else begin
      vs_last_q     <= vs_last_d;
      hs_last_q     <= hs_last_d;
      pending_q     <= pending_d;
      first_line_q  <= first_line_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      phase_x_q     <= phase_x_d;
      phase_y_q     <= phase_y_d;
      beat_cnt_q    <= beat_cnt_d;
      line_cnt_q    <= line_cnt_d;
`ifdef VIN_MIXCTL_LINECHK_EN
      line_err_q    <= line_err_d;
      ref_vld_q     <= ref_vld_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pend_mode_q <= pend_mode_d;
    pend_xoff_q <= pend_xoff_d;
    pend_yoff_q <= pend_yoff_d;
    act_xoff_q  <= act_xoff_d;
    act_yoff_q  <= act_yoff_d;
`ifdef VIN_MIXCTL_LINECHK_EN
    ref_len_q   <= ref_len_d;
`endif
  end

  assign cfg_ready   = ~pending_q;
  assign mode        = mode_q;
  assign phase_x     = phase_x_q;
  assign phase_y     = phase_y_q;
  assign frame_start = frame_start_q;
  assign beat_cnt    = beat_cnt_q;
  assign line_cnt    = line_cnt_q;
`ifdef VIN_MIXCTL_LINECHK_EN
  assign line_err    = line_err_q;
`else
  assign line_err    = 1'b0;
`endif

endmodule
